// File: rtl/cycle_start_gen_mc.sv
// Multi-channel cycle-start generator: each channel pulses when the synchronised time reaches
// its next scheduled start. Define CHANNEL_CATCHUP_EN to skip overdue starts after a time jump.
module cycle_start_gen_mc #(
    parameter int CH_NUM = 4,
    parameter int TIME_W = 64,
    parameter int LEN_W  = 32,
    parameter int ID_W   = 16
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic [TIME_W-1:0]                              iv_syn_clk,
    input  logic                                           i_cfg_wr,
    input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] iv_cfg_ch,
    input  logic                                           i_cfg_en,
    input  logic [TIME_W-1:0]                              iv_cfg_base,
    input  logic [LEN_W-1:0]                               iv_cfg_len,
    output logic                                           o_cfg_err,
    output logic [CH_NUM-1:0]                              ov_cycle_start,
    output logic [CH_NUM*ID_W-1:0]                         ov_cycle_id,
    output logic [CH_NUM-1:0]                              ov_ch_active
);

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CATCHUP = 2'd2,
        ST_PULSE   = 2'd3
    } state_t;

    logic [CH_NUM-1:0] w_ch_hit;
    logic              w_ch_ok;
    logic              w_len_bad;
    logic              w_reject;
    logic [CH_NUM-1:0] w_cfg_sel;
    logic              r_cfg_err;

    // One-hot decode of the write target; codes at or above CH_NUM hit nothing.
    always_comb begin
        w_ch_hit = {CH_NUM{1'b0}};
        for (int n = 0; n < CH_NUM; n++) begin
            w_ch_hit[n] = (iv_cfg_ch == CH_W'(n));
        end
    end

    assign w_ch_ok   = |w_ch_hit;
    assign w_len_bad = i_cfg_en & (iv_cfg_len == {LEN_W{1'b0}});
    assign w_reject  = i_cfg_wr & (~w_ch_ok | w_len_bad);
    assign w_cfg_sel = w_ch_hit & {CH_NUM{i_cfg_wr & ~w_reject}};

    // Rejected-write flag, high for the cycle after the offending write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_reject;
        end
    end

    assign o_cfg_err = r_cfg_err;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        state_t            r_state;
        state_t            w_state_nxt;
        logic [TIME_W-1:0] r_next_start;
        logic [TIME_W-1:0] w_next_start_nxt;
        logic [LEN_W-1:0]  r_len;
        logic [LEN_W-1:0]  w_len_nxt;
        logic [ID_W-1:0]   r_id;
        logic [ID_W-1:0]   w_id_nxt;
        logic [ID_W-1:0]   r_cyc_id;
        logic [ID_W-1:0]   w_cyc_id_nxt;
        logic              r_start;
        logic              w_start_nxt;
        logic              r_active;
        logic              w_active_nxt;
        logic [TIME_W-1:0] w_len_ext;
        logic              w_due;

        assign w_len_ext = {{(TIME_W-LEN_W){1'b0}}, r_len};
        assign w_due     = (r_next_start <= iv_syn_clk);

        // Next-state logic; a write to this channel overrides whatever the FSM would do.
        always_comb begin
            w_state_nxt      = r_state;
            w_next_start_nxt = r_next_start;
            w_len_nxt        = r_len;
            w_id_nxt         = r_id;
            w_cyc_id_nxt     = r_cyc_id;
            w_start_nxt      = 1'b0;
            if (w_cfg_sel[g]) begin
                w_next_start_nxt = iv_cfg_base;
                w_len_nxt        = iv_cfg_len;
                w_id_nxt         = {ID_W{1'b1}};
                w_state_nxt      = i_cfg_en ? ST_ARMED : ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_IDLE;
                    end
                    ST_ARMED: begin
                        if (w_due) begin
                            w_next_start_nxt = r_next_start + w_len_ext;
`ifdef CHANNEL_CATCHUP_EN
                            w_state_nxt = ST_CATCHUP;
`else
                            w_state_nxt = ST_PULSE;
`endif
                        end else begin
                            w_state_nxt = ST_ARMED;
                        end
                    end
`ifdef CHANNEL_CATCHUP_EN
                    // Overdue starts are consumed silently, one per clock.
                    ST_CATCHUP: begin
                        if (w_due) begin
                            w_next_start_nxt = r_next_start + w_len_ext;
                            w_state_nxt      = ST_CATCHUP;
                        end else begin
                            w_state_nxt = ST_PULSE;
                        end
                    end
`endif
                    ST_PULSE: begin
                        w_start_nxt  = 1'b1;
                        w_id_nxt     = r_id + ID_W'(1'b1);
                        w_cyc_id_nxt = r_id + ID_W'(1'b1);
                        w_state_nxt  = ST_ARMED;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
            w_active_nxt = (w_state_nxt != ST_IDLE);
        end

        // Channel state and registered outputs.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state      <= ST_IDLE;
                r_next_start <= {TIME_W{1'b0}};
                r_len        <= {LEN_W{1'b0}};
                r_id         <= {ID_W{1'b0}};
                r_cyc_id     <= {ID_W{1'b0}};
                r_start      <= 1'b0;
                r_active     <= 1'b0;
            end else begin
                r_state      <= w_state_nxt;
                r_next_start <= w_next_start_nxt;
                r_len        <= w_len_nxt;
                r_id         <= w_id_nxt;
                r_cyc_id     <= w_cyc_id_nxt;
                r_start      <= w_start_nxt;
                r_active     <= w_active_nxt;
            end
        end

        assign ov_cycle_start[g]            = r_start;
        assign ov_cycle_id[g*ID_W +: ID_W]  = r_cyc_id;
        assign ov_ch_active[g]              = r_active;
    end

endmodule

// File: tb/tb_cycle_start_gen_mc.sv
// Directed testbench for cycle_start_gen_mc; expectations adapt to CHANNEL_CATCHUP_EN.
module tb_cycle_start_gen_mc;

`ifdef CHANNEL_CATCHUP_EN
    localparam int EXTRA      = 1;
    localparam int JUMP_PULSE = 1;
    localparam int JUMP_LAST  = 0;
`else
    localparam int EXTRA      = 0;
    localparam int JUMP_PULSE = 11;
    localparam int JUMP_LAST  = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] syn_clk;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic        cfg_en;
    logic [63:0] cfg_base;
    logic [31:0] cfg_len;
    logic        cfg_err;
    logic [3:0]  cycle_start;
    logic [63:0] cycle_id;
    logic [3:0]  ch_active;

    // Second instance with a non-power-of-two channel count, so an out-of-range code exists.
    logic        b_cfg_wr;
    logic [1:0]  b_cfg_ch;
    logic        b_cfg_err;
    logic [2:0]  b_cycle_start;
    logic [47:0] b_cycle_id;
    logic [2:0]  b_ch_active;

    int checks   = 0;
    int failures = 0;

    cycle_start_gen_mc #(.CH_NUM(4), .TIME_W(64), .LEN_W(32), .ID_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .iv_syn_clk(syn_clk),
        .i_cfg_wr(cfg_wr), .iv_cfg_ch(cfg_ch), .i_cfg_en(cfg_en),
        .iv_cfg_base(cfg_base), .iv_cfg_len(cfg_len), .o_cfg_err(cfg_err),
        .ov_cycle_start(cycle_start), .ov_cycle_id(cycle_id), .ov_ch_active(ch_active)
    );

    cycle_start_gen_mc #(.CH_NUM(3), .TIME_W(64), .LEN_W(32), .ID_W(16)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .iv_syn_clk(syn_clk),
        .i_cfg_wr(b_cfg_wr), .iv_cfg_ch(b_cfg_ch), .i_cfg_en(cfg_en),
        .iv_cfg_base(cfg_base), .iv_cfg_len(cfg_len), .o_cfg_err(b_cfg_err),
        .ov_cycle_start(b_cycle_start), .ov_cycle_id(b_cycle_id), .ov_ch_active(b_ch_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic en, input logic [63:0] base,
                             input logic [31:0] len);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_en = en; cfg_base = base; cfg_len = len;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; syn_clk = 64'd0; cfg_wr = 1'b0; cfg_ch = 2'd0; cfg_en = 1'b0;
        cfg_base = 64'd0; cfg_len = 32'd0; b_cfg_wr = 1'b0; b_cfg_ch = 2'd0;
        #12;
        checks++; if (cycle_start !== 4'b0000) begin failures++; $display("FAIL reset_start: got %b expected 0000", cycle_start); end
        checks++; if (cycle_id !== 64'd0) begin failures++; $display("FAIL reset_id: got %h expected 0", cycle_id); end
        checks++; if (ch_active !== 4'b0000) begin failures++; $display("FAIL reset_active: got %b expected 0000", ch_active); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (ch_active !== 4'b0000) begin failures++; $display("FAIL reset_release_active: got %b expected 0000", ch_active); end
    endtask

    task automatic test_base_len();
        logic [3:0] exp_start;
        syn_clk = 64'd0;
        cfg_write(2'd0, 1'b1, 64'd1000, 32'd500);
        checks++; if (ch_active !== 4'b0001) begin failures++; $display("FAIL base_active: got %b expected 0001", ch_active); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL base_err: got %b expected 0", cfg_err); end
        for (int j = 1; j <= 200; j++) begin
            syn_clk = 64'(8 * j);
            tick();
            exp_start = ((j == 126 + EXTRA) || (j == 189 + EXTRA)) ? 4'b0001 : 4'b0000;
            checks++;
            if (cycle_start !== exp_start) begin
                failures++; $display("FAIL base_pulse j=%0d: got %b expected %b", j, cycle_start, exp_start);
            end
            if (j == 126 + EXTRA) begin
                checks++; if (cycle_id[15:0] !== 16'd0) begin failures++; $display("FAIL base_id0: got %0d expected 0", cycle_id[15:0]); end
            end
            if (j == 189 + EXTRA) begin
                checks++; if (cycle_id[15:0] !== 16'd1) begin failures++; $display("FAIL base_id1: got %0d expected 1", cycle_id[15:0]); end
            end
        end
    endtask

    task automatic test_reject();
        cfg_write(2'd2, 1'b1, 64'd3000, 32'd0);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL rej_len_err: got %b expected 1", cfg_err); end
        checks++; if (ch_active !== 4'b0001) begin failures++; $display("FAIL rej_len_active: got %b expected 0001", ch_active); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rej_len_err_clear: got %b expected 0", cfg_err); end
        checks++; if (ch_active !== 4'b0001) begin failures++; $display("FAIL rej_len_active2: got %b expected 0001", ch_active); end
        b_cfg_wr = 1'b1; b_cfg_ch = 2'd3; cfg_en = 1'b1; cfg_base = 64'hFFFF_FFFF_0000_0000; cfg_len = 32'd10;
        tick();
        b_cfg_wr = 1'b0;
        checks++; if (b_cfg_err !== 1'b1) begin failures++; $display("FAIL rej_ch_err: got %b expected 1", b_cfg_err); end
        checks++; if (b_ch_active !== 3'b000) begin failures++; $display("FAIL rej_ch_active: got %b expected 000", b_ch_active); end
        tick();
        checks++; if (b_cfg_err !== 1'b0) begin failures++; $display("FAIL rej_ch_err_clear: got %b expected 0", b_cfg_err); end
        b_cfg_wr = 1'b1; b_cfg_ch = 2'd2;
        tick();
        b_cfg_wr = 1'b0;
        checks++; if (b_cfg_err !== 1'b0) begin failures++; $display("FAIL valid_ch_err: got %b expected 0", b_cfg_err); end
        checks++; if (b_ch_active !== 3'b100) begin failures++; $display("FAIL valid_ch_active: got %b expected 100", b_ch_active); end
    endtask

    task automatic test_forward_jump();
        logic exp1;
        int   seen;
        seen = 0;
        syn_clk = 64'd50;
        cfg_write(2'd1, 1'b1, 64'd0, 32'd100);
        syn_clk = 64'd1050;
        for (int i = 1; i <= 30; i++) begin
            tick();
`ifdef CHANNEL_CATCHUP_EN
            exp1 = (i == 13);
`else
            exp1 = ((i % 2) == 0) && (i <= 22);
`endif
            checks++;
            if (cycle_start !== {2'b00, exp1, 1'b0}) begin
                failures++; $display("FAIL jump_pulse i=%0d: got %b expected %b", i, cycle_start, {2'b00, exp1, 1'b0});
            end
            if (cycle_start[1] === 1'b1) seen++;
        end
        checks++; if (seen != JUMP_PULSE) begin failures++; $display("FAIL jump_count: got %0d expected %0d", seen, JUMP_PULSE); end
        checks++; if (cycle_id[31:16] !== 16'(JUMP_LAST)) begin failures++; $display("FAIL jump_id: got %0d expected %0d", cycle_id[31:16], JUMP_LAST); end
        syn_clk = 64'd1099;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cycle_start[1] !== 1'b0) begin failures++; $display("FAIL jump_early i=%0d: got %b expected 0", i, cycle_start[1]); end
        end
        syn_clk = 64'd1100;
        for (int i = 0; i <= EXTRA; i++) begin
            tick();
            checks++; if (cycle_start[1] !== 1'b0) begin failures++; $display("FAIL jump_lat i=%0d: got %b expected 0", i, cycle_start[1]); end
        end
        tick();
        checks++; if (cycle_start[1] !== 1'b1) begin failures++; $display("FAIL jump_resume: got %b expected 1", cycle_start[1]); end
        checks++; if (cycle_id[31:16] !== 16'(JUMP_LAST + 1)) begin failures++; $display("FAIL jump_resume_id: got %0d expected %0d", cycle_id[31:16], JUMP_LAST + 1); end
    endtask

    task automatic test_reconfig();
        cfg_write(2'd1, 1'b0, 64'd0, 32'd0);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL disable_err: got %b expected 0", cfg_err); end
        checks++; if (ch_active !== 4'b0001) begin failures++; $display("FAIL disable_active: got %b expected 0001", ch_active); end
        syn_clk = 64'd2000;
        cfg_write(2'd0, 1'b1, 64'd5000, 32'd200);
        for (int i = 0; i < 5; i++) begin
            checks++; if (cycle_start !== 4'b0000) begin failures++; $display("FAIL reconf_nopulse i=%0d: got %b expected 0000", i, cycle_start); end
            tick();
        end
        checks++; if (cycle_id[15:0] !== 16'd1) begin failures++; $display("FAIL reconf_hold_id: got %0d expected 1", cycle_id[15:0]); end
        syn_clk = 64'd5000;
        for (int i = 0; i <= EXTRA; i++) begin
            tick();
            checks++; if (cycle_start !== 4'b0000) begin failures++; $display("FAIL reconf_lat i=%0d: got %b expected 0000", i, cycle_start); end
        end
        tick();
        checks++; if (cycle_start !== 4'b0001) begin failures++; $display("FAIL reconf_pulse: got %b expected 0001", cycle_start); end
        checks++; if (cycle_id[15:0] !== 16'd0) begin failures++; $display("FAIL reconf_id: got %0d expected 0", cycle_id[15:0]); end
    endtask

    task automatic test_simultaneous_reset();
        for (int c = 0; c < 4; c++) begin
            cfg_write(2'(c), 1'b1, 64'd6000, 32'd1000);
            checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL sim_err ch=%0d: got %b expected 0", c, cfg_err); end
        end
        checks++; if (ch_active !== 4'b1111) begin failures++; $display("FAIL sim_active: got %b expected 1111", ch_active); end
        syn_clk = 64'd6000;
        for (int i = 0; i <= EXTRA; i++) begin
            tick();
            checks++; if (cycle_start !== 4'b0000) begin failures++; $display("FAIL sim_lat i=%0d: got %b expected 0000", i, cycle_start); end
        end
        tick();
        checks++; if (cycle_start !== 4'b1111) begin failures++; $display("FAIL sim_pulse: got %b expected 1111", cycle_start); end
        checks++; if (cycle_id !== 64'd0) begin failures++; $display("FAIL sim_id: got %h expected 0", cycle_id); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (cycle_start !== 4'b0000) begin failures++; $display("FAIL rst_mid_start: got %b expected 0000", cycle_start); end
        checks++; if (ch_active !== 4'b0000) begin failures++; $display("FAIL rst_mid_active: got %b expected 0000", ch_active); end
        checks++; if (cycle_id !== 64'd0) begin failures++; $display("FAIL rst_mid_id: got %h expected 0", cycle_id); end
        syn_clk = 64'd8000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (cycle_start !== 4'b0000 || ch_active !== 4'b0000) begin
                failures++; $display("FAIL rst_release i=%0d: got start=%b active=%b expected 0000/0000", i, cycle_start, ch_active);
            end
        end
    endtask

    initial begin
        test_reset();
        test_base_len();
        test_reject();
        test_forward_jump();
        test_reconfig();
        test_simultaneous_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
